latch_chain_monitor: RTL and testbench
======================================

// Module: latch_chain_monitor
// PURPOSE
//  Parametrised self-checking monitor for latch/flop frontend tests: models the expected
//  DUT output as a DEPTH-stage registered copy of din (optionally inverted), compares it
//  against dut_q each clock, and keeps sticky fail, counters and first-failure capture.
//  Sits in the testbench beside the DUT; synthesisable so it can also go through the flow.
// PARAMETERS
//  WIDTH         1   data width of din / dut_q
//  DEPTH         1   register stages between din and expected value (>=1)
//  INVERT        0   1: expected = ~pipe output
//  WARMUP        2   cycles after en rises before comparison starts (0..255)
//  CNT_W         16  width of mismatch and cycle counters
//  STOP_ON_FAIL  1   1: enter FAIL on first mismatch; 0: keep checking, count all
// PORTS
//  clk               in   1       clock; all state on rising edge
//  rst               in   1       asynchronous, active-high reset
//  clear             in   1       synchronous clear of pipe, counters, captures, state
//  en                in   1       check enable
//  din               in   WIDTH   stimulus driven into DUT (model input)
//  dut_q             in   WIDTH   DUT output under test
//  state             out  2       IDLE=0 WARMUP=1 CHECK=2 FAIL=3
//  fail              out  1       sticky: any mismatch since reset/clear
//  mismatch_cnt      out  CNT_W   mismatching compares, saturating at all-ones
//  cycle_cnt         out  CNT_W   compares performed, saturating
//  first_fail_cycle  out  CNT_W   cycle_cnt value at first mismatch
//  first_fail_mask   out  WIDTH   expected ^ dut_q at first mismatch
// BEHAVIOUR
//  - Reset (async) and clear (sync, priority over all else): state=IDLE, all outputs 0,
//    pipe data 0, pipe valid bits 0.
//  - Pipe: every clock while en=1, stage0<=din, stageN<=stageN-1, valid shifts in 1;
//    en=0 holds pipe contents. exp = stage[DEPTH-1] ^ {WIDTH{INVERT}}.
//  - FSM: IDLE->WARMUP on en=1 (warm counter loads 0; WARMUP=0 goes straight to CHECK).
//    WARMUP->CHECK when warm counter reaches WARMUP-1. CHECK/WARMUP->IDLE on en=0
//    (counters, fail, captures held). CHECK->FAIL on mismatch when STOP_ON_FAIL=1.
//    FAIL is absorbing until rst/clear; en ignored in FAIL.
//  - Compare occurs at a clock edge only when state==CHECK, en=1 and valid[DEPTH-1]=1;
//    compare with invalid pipe data is skipped, not counted.
//  - Per compare: cycle_cnt+1. If exp!=dut_q: mismatch_cnt+1, fail<=1; if fail was 0,
//    first_fail_cycle<=cycle_cnt (pre-increment value), first_fail_mask<=exp^dut_q.
//  - All results registered: visible the cycle after the comparing edge (latency 1).
//  - Saturation: counters stop at 2^CNT_W-1, never wrap; fail stays 1 regardless.
//  - Re-entering CHECK after en drop keeps counters; pipe valid state is preserved.
// STRUCTURE
//  - Package latch_chk_pkg: state encoding constants/typedef (IDLE/WARMUP/CHECK/FAIL),
//    saturating-increment function.
//  - One sub-module: expect_pipe (WIDTH, DEPTH, INVERT; clk, rst, clear, shift, din ->
//    exp, exp_valid). Top holds FSM, counters and capture registers.
// TESTING
//  - Matching DUT (dut_q = registered ~din), DEPTH=1 INVERT=1 WARMUP=2, 100 en cycles ->
//    fail=0, mismatch_cnt=0, cycle_cnt=97 (100 - 2 warmup - 1 invalid pipe).
//  - Single-bit fault: WIDTH=4, flip dut_q[2] at compare #10, STOP_ON_FAIL=1 ->
//    state=FAIL next cycle, first_fail_cycle=10, first_fail_mask=4'b0100, mismatch_cnt=1.
//  - STOP_ON_FAIL=0, fault every 4th compare over 40 compares -> mismatch_cnt=10,
//    state=CHECK, first_fail_cycle=3.
//  - Saturation: CNT_W=4, persistent mismatch 30 compares -> mismatch_cnt=15, cycle_cnt=15.
//  - en dropped mid-CHECK for 5 cycles then restored -> IDLE during gap, counters frozen,
//    WARMUP repeated, cycle_cnt resumes from held value; no spurious mismatch.
//  - rst asserted between clock edges in FAIL -> outputs 0 and state=IDLE immediately;
//    clear=1 with en=1 on same edge -> IDLE, counters 0.

Source files
------------

// File: rtl/latch_chk_pkg.sv
// Shared state encoding and helpers for the latch chain monitor.
package latch_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  // Counters narrower than 32 bits are zero-extended in and truncated out.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/latch_chain_monitor_expect_pipe.sv
// Reference pipe: DEPTH-stage copy of din with a valid bit per stage.
module expect_pipe #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 1,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] exp,
  output logic             exp_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_vld <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_vld <= '0;
    end else if (shift) begin
      r_data[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_data[i] <= r_data[i-1];
      r_vld <= (r_vld << 1) | DEPTH'(1);
    end
  end

  assign exp       = r_data[DEPTH-1] ^ {WIDTH{INVERT}};
  assign exp_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/latch_chain_monitor.sv
// Self-checking monitor: compares dut_q against a delayed copy of din
// and keeps sticky fail, saturating counters and first-failure capture.
module latch_chain_monitor
  import latch_chk_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int DEPTH        = 1,
  parameter bit INVERT       = 1'b0,
  parameter int WARMUP       = 2,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dut_q,
  output logic [1:0]       state,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] first_fail_mask
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});
  localparam logic [7:0]  WU_LAST = 8'(WARMUP - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_warm;
  logic [7:0]       w_warm_nxt;
  logic [WIDTH-1:0] w_exp;
  logic             w_vld;
  logic             w_cmp;
  logic             w_miss;
  logic             r_fail;
  logic [CNT_W-1:0] r_mis;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ffc;
  logic [WIDTH-1:0] r_ffm;

  expect_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .INVERT (INVERT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift     (en),
    .din       (din),
    .exp       (w_exp),
    .exp_valid (w_vld)
  );

  assign w_cmp  = (r_state == ST_CHECK) && en && w_vld;
  assign w_miss = w_cmp && (w_exp != dut_q);

  always_comb begin
    w_next     = r_state;
    w_warm_nxt = r_warm;
    unique case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_warm_nxt = '0;
          w_next     = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (!en)                   w_next = ST_IDLE;
        else if (r_warm == WU_LAST) w_next = ST_CHECK;
        else                       w_warm_nxt = r_warm + 8'd1;
      end
      ST_CHECK: begin
        if (!en)                          w_next = ST_IDLE;
        else if (w_miss && STOP_ON_FAIL) w_next = ST_FAIL;
      end
      ST_FAIL: w_next = ST_FAIL;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_warm  <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_warm  <= '0;
    end else begin
      r_state <= w_next;
      r_warm  <= w_warm_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail <= 1'b0;
      r_mis  <= '0;
      r_cyc  <= '0;
      r_ffc  <= '0;
      r_ffm  <= '0;
    end else if (clear) begin
      r_fail <= 1'b0;
      r_mis  <= '0;
      r_cyc  <= '0;
      r_ffc  <= '0;
      r_ffm  <= '0;
    end else if (w_cmp) begin
      r_cyc <= CNT_W'(sat_inc(32'(r_cyc), CNT_MAX));
      if (w_miss) begin
        r_mis  <= CNT_W'(sat_inc(32'(r_mis), CNT_MAX));
        r_fail <= 1'b1;
        // Capture uses the count before this compare is added.
        if (!r_fail) begin
          r_ffc <= r_cyc;
          r_ffm <= w_exp ^ dut_q;
        end
      end
    end
  end

  assign state            = r_state;
  assign fail             = r_fail;
  assign mismatch_cnt     = r_mis;
  assign cycle_cnt        = r_cyc;
  assign first_fail_cycle = r_ffc;
  assign first_fail_mask  = r_ffm;

endmodule

// File: tb/tb_latch_chain_monitor.sv
// Four monitor configurations driven by shared random stimulus and
// checked every cycle against a queue-based behavioural model.
module tb_latch_chain_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       en;
  logic [3:0] din;
  logic [3:0] flt [4];
  logic       cmp_on = 1'b0;
  int         fmode = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  localparam int P_D    [4] = '{1, 1, 1, 3};
  localparam int P_I    [4] = '{1, 1, 1, 0};
  localparam int P_WU   [4] = '{2, 2, 2, 0};
  localparam int P_CW   [4] = '{16, 16, 4, 16};
  localparam int P_STOP [4] = '{1, 0, 0, 0};

  // Stand-in DUTs: enabled flop of ~din, and a 3-deep enabled delay of din.
  logic [3:0] dq1;
  logic [3:0] dq3 [3];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dq1 <= '0;
      for (int i = 0; i < 3; i++) dq3[i] <= '0;
    end else if (en) begin
      dq1    <= ~din;
      dq3[0] <= din;
      dq3[1] <= dq3[0];
      dq3[2] <= dq3[1];
    end
  end

  logic [3:0] q_a, q_b, q_c, q_d;
  assign q_a = dq1 ^ flt[0];
  assign q_b = dq1 ^ flt[1];
  assign q_c = dq1 ^ flt[2];
  assign q_d = dq3[2] ^ flt[3];

  logic [1:0]  st_a, st_b, st_c, st_d;
  logic        f_a, f_b, f_c, f_d;
  logic [15:0] mc_a, cc_a, ffc_a, mc_b, cc_b, ffc_b, mc_d, cc_d, ffc_d;
  logic [3:0]  mc_c, cc_c, ffc_c;
  logic [3:0]  ffm_a, ffm_b, ffm_c, ffm_d;

  latch_chain_monitor #(.WIDTH(4), .DEPTH(1), .INVERT(1'b1), .WARMUP(2),
    .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .din(din), .dut_q(q_a),
    .state(st_a), .fail(f_a), .mismatch_cnt(mc_a), .cycle_cnt(cc_a),
    .first_fail_cycle(ffc_a), .first_fail_mask(ffm_a));

  latch_chain_monitor #(.WIDTH(4), .DEPTH(1), .INVERT(1'b1), .WARMUP(2),
    .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .din(din), .dut_q(q_b),
    .state(st_b), .fail(f_b), .mismatch_cnt(mc_b), .cycle_cnt(cc_b),
    .first_fail_cycle(ffc_b), .first_fail_mask(ffm_b));

  latch_chain_monitor #(.WIDTH(4), .DEPTH(1), .INVERT(1'b1), .WARMUP(2),
    .CNT_W(4), .STOP_ON_FAIL(1'b0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .din(din), .dut_q(q_c),
    .state(st_c), .fail(f_c), .mismatch_cnt(mc_c), .cycle_cnt(cc_c),
    .first_fail_cycle(ffc_c), .first_fail_mask(ffm_c));

  latch_chain_monitor #(.WIDTH(4), .DEPTH(3), .INVERT(1'b0), .WARMUP(0),
    .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_d (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .din(din), .dut_q(q_d),
    .state(st_d), .fail(f_d), .mismatch_cnt(mc_d), .cycle_cnt(cc_d),
    .first_fail_cycle(ffc_d), .first_fail_mask(ffm_d));

  // Model: hist holds every din sampled with en since reset/clear.
  logic [3:0] hist [$];
  int         m_st [4];
  int         m_rem [4];
  int         m_mc [4];
  int         m_cc [4];
  int         m_ffc [4];
  bit         m_fail [4];
  logic [3:0] m_ffm [4];

  function automatic logic [3:0] qv(input int k);
    case (k)
      0: return q_a;
      1: return q_b;
      2: return q_c;
      default: return q_d;
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_st[k] = 0; m_rem[k] = 0; m_mc[k] = 0; m_cc[k] = 0;
      m_ffc[k] = 0; m_fail[k] = 1'b0; m_ffm[k] = '0;
    end
    hist.delete();
  endtask

  task automatic m_step(input int k);
    int         mx;
    bit         valid;
    logic [3:0] e;
    logic [3:0] q;
    mx    = (1 << P_CW[k]) - 1;
    valid = (hist.size() >= P_D[k]);
    e     = valid ? hist[hist.size() - P_D[k]] : 4'h0;
    if (P_I[k] != 0) e = ~e;
    q = qv(k);
    case (m_st[k])
      0: if (en) begin
        m_rem[k] = P_WU[k];
        m_st[k]  = (P_WU[k] == 0) ? 2 : 1;
      end
      1: begin
        if (!en) m_st[k] = 0;
        else if (m_rem[k] <= 1) m_st[k] = 2;
        else m_rem[k] = m_rem[k] - 1;
      end
      2: begin
        if (!en) m_st[k] = 0;
        else if (valid) begin
          if (e !== q) begin
            if (!m_fail[k]) begin
              m_ffc[k] = m_cc[k];
              m_ffm[k] = e ^ q;
            end
            m_fail[k] = 1'b1;
            if (m_mc[k] < mx) m_mc[k] = m_mc[k] + 1;
            if (P_STOP[k] != 0) m_st[k] = 3;
          end
          if (m_cc[k] < mx) m_cc[k] = m_cc[k] + 1;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst || clear) m_reset();
      else begin
        for (int k = 0; k < 4; k++) m_step(k);
        if (en) begin
          hist.push_back(din);
          if (hist.size() > 8) void'(hist.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic [1:0] st, input logic f,
                          input logic [31:0] mc, input logic [31:0] cc,
                          input logic [31:0] ffc, input logic [3:0] ffm);
    string p;
    p = $sformatf("inst%0d", k);
    chk({p, ".state"}, 32'(st), 32'(m_st[k]));
    chk({p, ".fail"}, 32'(f), 32'(m_fail[k]));
    chk({p, ".mismatch_cnt"}, mc, 32'(m_mc[k]));
    chk({p, ".cycle_cnt"}, cc, 32'(m_cc[k]));
    chk({p, ".first_fail_cycle"}, ffc, 32'(m_ffc[k]));
    chk({p, ".first_fail_mask"}, 32'(ffm), 32'(m_ffm[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk_inst(0, st_a, f_a, 32'(mc_a), 32'(cc_a), 32'(ffc_a), ffm_a);
      chk_inst(1, st_b, f_b, 32'(mc_b), 32'(cc_b), 32'(ffc_b), ffm_b);
      chk_inst(2, st_c, f_c, 32'(mc_c), 32'(cc_c), 32'(ffc_c), ffm_c);
      chk_inst(3, st_d, f_d, 32'(mc_d), 32'(cc_d), 32'(ffc_d), ffm_d);
    end
  end

  task automatic update_faults();
    for (int k = 0; k < 4; k++) flt[k] = '0;
    case (fmode)
      2: begin
        if (m_st[0] == 2 && m_cc[0] == 10) flt[0] = 4'b0100;
        if (m_cc[1] % 4 == 3 && m_cc[1] < 40) flt[1] = 4'($urandom_range(1, 15));
        flt[2] = 4'($urandom_range(1, 15));
      end
      4: for (int k = 0; k < 4; k++)
           if ($urandom_range(0, 15) == 0) flt[k] = 4'($urandom_range(1, 15));
      5: flt[0] = 4'hF;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    din = 4'($urandom);
    update_faults();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; en = 1'b0; din = '0;
    for (int k = 0; k < 4; k++) flt[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("lit_reset_state", 32'(st_a), 0);
    chk("lit_reset_cycle_cnt", 32'(cc_a), 0);
    chk("lit_reset_fail", 32'(f_d), 0);

    // Matching DUT for 100 enabled edges
    en = 1'b1;
    repeat (100) tick();
    chk("lit_match_cycle_cnt", 32'(cc_a), 97);
    chk("lit_match_mismatch", 32'(mc_a), 0);
    chk("lit_match_fail", 32'(f_a), 0);
    chk("lit_match_cycle_cnt_b", 32'(cc_b), 97);
    en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("lit_clear_cycle_cnt", 32'(cc_a), 0);

    // Faults: single bit on A, every 4th on B, persistent on C
    fmode = 2;
    update_faults();
    en = 1'b1;
    repeat (43) tick();
    chk("lit_stop_state", 32'(st_a), 3);
    chk("lit_stop_ffc", 32'(ffc_a), 10);
    chk("lit_stop_ffm", 32'(ffm_a), 4);
    chk("lit_stop_mismatch", 32'(mc_a), 1);
    chk("lit_every4_mismatch", 32'(mc_b), 10);
    chk("lit_every4_state", 32'(st_b), 2);
    chk("lit_every4_ffc", 32'(ffc_b), 3);
    chk("lit_every4_cycle_cnt", 32'(cc_b), 40);
    chk("lit_sat_mismatch", 32'(mc_c), 15);
    chk("lit_sat_cycle_cnt", 32'(cc_c), 15);

    // en gap of 5 cycles then resume
    fmode = 0;
    update_faults();
    en = 1'b0;
    repeat (5) tick();
    chk("lit_gap_state", 32'(st_b), 0);
    chk("lit_gap_cycle_cnt", 32'(cc_b), 40);
    en = 1'b1;
    repeat (10) tick();
    chk("lit_resume_cycle_cnt", 32'(cc_b), 47);
    chk("lit_resume_mismatch", 32'(mc_b), 10);
    chk("lit_resume_fail_held", 32'(st_a), 3);

    // Random traffic
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fmode = 4;
    repeat (400) begin
      tick();
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
    end
    clear = 1'b0;

    // Drive A into FAIL, then async reset mid-cycle
    fmode = 0;
    update_faults();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fmode = 5;
    update_faults();
    en = 1'b1;
    for (int i = 0; i < 20 && st_a != 2'd3; i++) tick();
    chk("lit_reach_fail", 32'(st_a), 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_async_state", 32'(st_a), 0);
    chk("lit_async_fail", 32'(f_a), 0);
    chk("lit_async_mismatch", 32'(mc_a), 0);
    chk("lit_async_ffm", 32'(ffm_a), 0);
    #1;
    rst = 1'b0;
    fmode = 0;
    update_faults();
    repeat (10) tick();
    chk("lit_pre_clear_cnt", 32'(cc_a), 7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("lit_clear_en_state", 32'(st_a), 0);
    chk("lit_clear_en_cnt", 32'(cc_a), 0);
    en = 1'b0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
